// File: rtl/decimal_scan_controller_pkg.sv
// decimal_pkg -- BCD digit constants, blanking code and scan state type shared by the scan controller.
// Revision 1.0
`default_nettype none

package decimal_pkg;

   localparam logic [3:0] ZERO       = 4'd0;
   localparam logic [3:0] ONE        = 4'd1;
   localparam logic [3:0] TWO        = 4'd2;
   localparam logic [3:0] THREE      = 4'd3;
   localparam logic [3:0] FOUR       = 4'd4;
   localparam logic [3:0] FIVE       = 4'd5;
   localparam logic [3:0] SIX        = 4'd6;
   localparam logic [3:0] SEVEN      = 4'd7;
   localparam logic [3:0] EIGHT      = 4'd8;
   localparam logic [3:0] NINE       = 4'd9;
   localparam logic [3:0] BLANK_CODE = 4'b1111;

   typedef enum logic [0:0] {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } scan_state_e;

   // Out-of-range BCD load nibbles clamp to the largest legal digit.
   function automatic logic [3:0] sat_digit(input logic [3:0] v);
      return (v > NINE) ? NINE : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/decimal_scan_controller_if.sv
// decimal_scan_controller_if -- counter command strobes and display outputs of the scan controller.
// Revision 1.0
`default_nettype none

interface decimal_scan_controller_if #(
   parameter int DIGITS = 4
);
   logic                  clear_i;
   logic                  load_i;
   logic [4*DIGITS-1:0]   load_value_i;
   logic                  count_en_i;
   logic                  up_i;
   logic [4*DIGITS-1:0]   count_o;
   logic                  carry_o;
   logic [3:0]            bcd_o;
   logic [DIGITS-1:0]     digit_sel_o_;

   modport master (
      output clear_i, load_i, load_value_i, count_en_i, up_i,
      input  count_o, carry_o, bcd_o, digit_sel_o_
   );

   modport slave (
      input  clear_i, load_i, load_value_i, count_en_i, up_i,
      output count_o, carry_o, bcd_o, digit_sel_o_
   );
endinterface

`default_nettype wire

// File: rtl/decimal_scan_controller_bcd_digit_counter.sv
// bcd_digit_counter -- one decade of the ripple BCD up/down counter with clear and saturating load.
// Revision 1.0
`default_nettype none

module bcd_digit_counter
   import decimal_pkg::*;
(
   input  wire logic       clk_i,
   input  wire logic       reset_i_,
   input  wire logic       clear_i,
   input  wire logic       load_i,
   input  wire logic [3:0] load_value_i,
   input  wire logic       count_en_i,
   input  wire logic       up_i,
   input  wire logic       carry_i,
   output logic [3:0]      digit_o,
   output logic            carry_o
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;
   logic       w_step;
   logic       w_at_limit;

   always_comb begin
      w_step     = count_en_i & carry_i & ~clear_i & ~load_i;
      w_at_limit = up_i ? (digit_q == NINE) : (digit_q == ZERO);
      digit_d    = digit_q;
      if (clear_i) begin
         digit_d = ZERO;
      end else if (load_i) begin
         digit_d = sat_digit(load_value_i);
      end else if (w_step) begin
         if (w_at_limit) begin
            digit_d = up_i ? ZERO : NINE;
         end else begin
            digit_d = up_i ? (digit_q + 4'd1) : (digit_q - 4'd1);
         end
      end
      carry_o = w_step & w_at_limit;
   end

   always_ff @(posedge clk_i or negedge reset_i_) begin
      if (!reset_i_) begin
         digit_q <= ZERO;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o = digit_q;

endmodule

`default_nettype wire

// File: rtl/decimal_scan_controller.sv
// decimal_scan_controller -- ripple BCD up/down counter with a time-multiplexed, blanked digit scan.
// Revision 1.0
`default_nettype none

module decimal_scan_controller
   import decimal_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  wire logic                 clk_i,
   input  wire logic                 reset_i_,
   decimal_scan_controller_if.slave  bus
);

   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int KW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
   localparam logic [KW-1:0] K_LAST     = KW'(DIGITS - 1);

   logic [4*DIGITS-1:0] w_count;
   logic [DIGITS:0]     w_carry;

   scan_state_e         state_q, state_d;
   logic [CW-1:0]       cnt_q,   cnt_d;
   logic [KW-1:0]       k_q,     k_d;
   logic [3:0]          bcd_q,   bcd_d;
   logic [DIGITS-1:0]   sel_q,   sel_d;
   logic                carry_q, carry_d;

   // Digit 0 always has carry-in; higher digits step only on the ripple from below.
   assign w_carry[0] = 1'b1;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         bcd_digit_counter u_digit (
            .clk_i        (clk_i),
            .reset_i_     (reset_i_),
            .clear_i      (bus.clear_i),
            .load_i       (bus.load_i),
            .load_value_i (bus.load_value_i[4*i +: 4]),
            .count_en_i   (bus.count_en_i),
            .up_i         (bus.up_i),
            .carry_i      (w_carry[i]),
            .digit_o      (w_count[4*i +: 4]),
            .carry_o      (w_carry[i+1])
         );
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      k_d     = k_q;
      case (state_q)
         SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               cnt_d   = '0;
               k_d     = (k_q == K_LAST) ? '0 : (k_q + KW'(1));
               state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
            end
         end
         BLANK: begin
            if ((BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST)) begin
               cnt_d   = '0;
               state_d = SHOW;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = BLANK;
         end
      endcase

      // Code and select are derived from the same next state so they switch on one edge.
      bcd_d = BLANK_CODE;
      sel_d = '1;
      if (state_d == SHOW) begin
         bcd_d = w_count[{k_d, 2'b00} +: 4];
         sel_d = ~(DIGITS'(1) << k_d);
      end

      carry_d = w_carry[DIGITS];
   end

   always_ff @(posedge clk_i or negedge reset_i_) begin
      if (!reset_i_) begin
         state_q <= BLANK;
         cnt_q   <= '0;
         k_q     <= '0;
         bcd_q   <= BLANK_CODE;
         sel_q   <= '1;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         bcd_q   <= bcd_d;
         sel_q   <= sel_d;
         carry_q <= carry_d;
      end
   end

   assign bus.count_o      = w_count;
   assign bus.carry_o      = carry_q;
   assign bus.bcd_o        = bcd_q;
   assign bus.digit_sel_o_ = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_decimal_scan_controller.sv
// tb_decimal_scan_controller -- randomized self-checking bench against a decimal-arithmetic model.
// Revision 1.0
`default_nettype none

module tb_decimal_scan_controller;

   localparam int D    = 4;
   localparam int S    = 3;
   localparam int B    = 2;
   localparam int MAXV = 9999;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   int unsigned m_cnt;
   int unsigned m_prev;
   bit          m_carry;
   int          t_edges;

   decimal_scan_controller_if #(.DIGITS(D)) bus ();

   decimal_scan_controller #(
      .DIGITS       (D),
      .SCAN_DIV     (S),
      .BLANK_CYCLES (B)
   ) dut (
      .clk_i    (clk),
      .reset_i_ (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int unsigned v);
      logic [15:0] r;
      int unsigned pw;
      pw = 1;
      r  = '0;
      for (int i = 0; i < D; i++) begin
         r[i*4 +: 4] = 4'((v / pw) % 10);
         pw = pw * 10;
      end
      return r;
   endfunction

   function automatic int unsigned sat_val(input logic [15:0] lv);
      int unsigned v;
      int unsigned nib;
      v = 0;
      for (int i = D - 1; i >= 0; i--) begin
         nib = lv[i*4 +: 4];
         if (nib > 9) nib = 9;
         v = v * 10 + nib;
      end
      return v;
   endfunction

   function automatic bit exp_show();
      return (t_edges >= B) && (((t_edges - B) % (S + B)) < S);
   endfunction

   function automatic int exp_slot();
      return ((t_edges - B) / (S + B)) % D;
   endfunction

   function automatic int exp_off();
      return (t_edges - B) % (S + B);
   endfunction

   function automatic logic [3:0] exp_bcd();
      logic [15:0] p;
      p = to_bcd(m_prev);
      if (!exp_show()) return 4'hF;
      return p[exp_slot()*4 +: 4];
   endfunction

   function automatic logic [3:0] exp_sel();
      logic [3:0] s;
      s = 4'hF;
      if (exp_show()) s[exp_slot()] = 1'b0;
      return s;
   endfunction

   task automatic step(input logic clr, input logic ld, input logic [15:0] lv,
                       input logic en, input logic up);
      bus.clear_i      = clr;
      bus.load_i       = ld;
      bus.load_value_i = lv;
      bus.count_en_i   = en;
      bus.up_i         = up;
      @(posedge clk);
      m_prev  = m_cnt;
      m_carry = 1'b0;
      if (clr) begin
         m_cnt = 0;
      end else if (ld) begin
         m_cnt = sat_val(lv);
      end else if (en) begin
         if (up) begin
            m_carry = (m_cnt == MAXV);
            m_cnt   = (m_cnt + 1) % (MAXV + 1);
         end else begin
            m_carry = (m_cnt == 0);
            m_cnt   = (m_cnt == 0) ? MAXV : m_cnt - 1;
         end
      end
      t_edges++;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_prev  = 0;
      m_carry = 1'b0;
      t_edges = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.clear_i = 1'b0; bus.load_i = 1'b0; bus.load_value_i = '0;
      bus.count_en_i = 1'b0; bus.up_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      n_cmp++;
      if (bus.count_o !== 16'h0 || bus.carry_o !== 1'b0 || bus.bcd_o !== 4'hF || bus.digit_sel_o_ !== 4'hF) begin
         n_bad++;
         $display("FAIL reset_state: count=%h carry=%b bcd=%h sel=%b, want 0000 0 f 1111",
                  bus.count_o, bus.carry_o, bus.bcd_o, bus.digit_sel_o_);
      end
      for (int i = 0; i < 2 * D * (S + B) + 2; i++) begin
         idle();
         n_cmp++;
         if (bus.bcd_o !== exp_bcd() || bus.digit_sel_o_ !== exp_sel()) begin
            n_bad++;
            $display("FAIL scan_idle[%0d]: bcd=%h sel=%b, want %h %b",
                     t_edges, bus.bcd_o, bus.digit_sel_o_, exp_bcd(), exp_sel());
         end
      end
   endtask

   task automatic test_carry_wrap();
      step(1'b0, 1'b1, 16'h0999, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      n_cmp++;
      if (bus.count_o !== 16'h1000 || bus.carry_o !== 1'b0) begin
         n_bad++;
         $display("FAIL ripple_up: count=%h carry=%b, want 1000 0", bus.count_o, bus.carry_o);
      end
      step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      n_cmp++;
      if (bus.count_o !== 16'h0000 || bus.carry_o !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_up: count=%h carry=%b, want 0000 1", bus.count_o, bus.carry_o);
      end
      idle();
      n_cmp++;
      if (bus.carry_o !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap_up_pulse: carry=%b, want 0", bus.carry_o);
      end
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      n_cmp++;
      if (bus.count_o !== 16'h9999 || bus.carry_o !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_down: count=%h carry=%b, want 9999 1", bus.count_o, bus.carry_o);
      end
      idle();
      n_cmp++;
      if (bus.carry_o !== 1'b0 || bus.count_o !== 16'h9999) begin
         n_bad++;
         $display("FAIL wrap_down_pulse: count=%h carry=%b, want 9999 0", bus.count_o, bus.carry_o);
      end
   endtask

   task automatic test_priority();
      step(1'b0, 1'b1, 16'h3AF5, 1'b0, 1'b1);
      n_cmp++;
      if (bus.count_o !== 16'h3995) begin
         n_bad++;
         $display("FAIL load_saturate: count=%h, want 3995", bus.count_o);
      end
      step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
      n_cmp++;
      if (bus.count_o !== 16'h0000 || bus.carry_o !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_priority: count=%h carry=%b, want 0000 0", bus.count_o, bus.carry_o);
      end
      step(1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
      n_cmp++;
      if (bus.count_o !== 16'h9999 || bus.carry_o !== 1'b0) begin
         n_bad++;
         $display("FAIL load_priority: count=%h carry=%b, want 9999 0", bus.count_o, bus.carry_o);
      end
      step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
      n_cmp++;
      if (bus.count_o !== 16'h0000 || bus.carry_o !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_no_carry: count=%h carry=%b, want 0000 0", bus.count_o, bus.carry_o);
      end
   endtask

   task automatic test_live_update();
      int guard;
      step(1'b0, 1'b1, 16'h0049, 1'b0, 1'b1);
      guard = 0;
      while (!(exp_show() && exp_slot() == 1 && exp_off() == 0) && guard < 4 * D * (S + B)) begin
         idle();
         guard++;
      end
      n_cmp++;
      if (bus.digit_sel_o_ !== 4'b1101 || bus.bcd_o !== 4'd4) begin
         n_bad++;
         $display("FAIL live_enter: sel=%b bcd=%h, want 1101 4", bus.digit_sel_o_, bus.bcd_o);
      end
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      n_cmp++;
      if (bus.count_o !== 16'h0050 || bus.bcd_o !== 4'd4 || bus.digit_sel_o_ !== 4'b1101) begin
         n_bad++;
         $display("FAIL live_lag: count=%h bcd=%h sel=%b, want 0050 4 1101",
                  bus.count_o, bus.bcd_o, bus.digit_sel_o_);
      end
      idle();
      n_cmp++;
      if (bus.bcd_o !== 4'd5 || bus.digit_sel_o_ !== 4'b1101) begin
         n_bad++;
         $display("FAIL live_update: bcd=%h sel=%b, want 5 1101", bus.bcd_o, bus.digit_sel_o_);
      end
   endtask

   task automatic test_async_reset();
      int guard;
      step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
      guard = 0;
      while (!(exp_show() && exp_slot() == 2 && exp_off() == 1) && guard < 4 * D * (S + B)) begin
         idle();
         guard++;
      end
      n_cmp++;
      if (bus.digit_sel_o_ !== 4'b1011 || bus.bcd_o !== 4'd2) begin
         n_bad++;
         $display("FAIL pre_reset_slot: sel=%b bcd=%h, want 1011 2", bus.digit_sel_o_, bus.bcd_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.count_o !== 16'h0 || bus.carry_o !== 1'b0 || bus.bcd_o !== 4'hF || bus.digit_sel_o_ !== 4'hF) begin
         n_bad++;
         $display("FAIL async_reset: count=%h carry=%b bcd=%h sel=%b, want 0000 0 f 1111",
                  bus.count_o, bus.carry_o, bus.bcd_o, bus.digit_sel_o_);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < S + B + 1; i++) begin
         idle();
         n_cmp++;
         if (bus.bcd_o !== exp_bcd() || bus.digit_sel_o_ !== exp_sel()) begin
            n_bad++;
            $display("FAIL restart_scan[%0d]: bcd=%h sel=%b, want %h %b",
                     t_edges, bus.bcd_o, bus.digit_sel_o_, exp_bcd(), exp_sel());
         end
      end
   endtask

   task automatic test_random();
      logic        clr, ld, en, up;
      logic [15:0] lv;
      int          r;
      for (int i = 0; i < 400; i++) begin
         r   = $urandom_range(0, 99);
         clr = (r < 3);
         ld  = (r >= 3 && r < 12);
         en  = ($urandom_range(0, 9) < 7);
         up  = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       lv = 16'h9999;
            1:       lv = 16'h0000;
            2:       lv = 16'h9990;
            default: lv = 16'($urandom);
         endcase
         step(clr, ld, lv, en, up);
         n_cmp++;
         if (bus.count_o !== to_bcd(m_cnt) || bus.carry_o !== m_carry) begin
            n_bad++;
            $display("FAIL rand_count[%0d]: count=%h carry=%b, want %h %b",
                     i, bus.count_o, bus.carry_o, to_bcd(m_cnt), m_carry);
         end
         n_cmp++;
         if (bus.bcd_o !== exp_bcd() || bus.digit_sel_o_ !== exp_sel()) begin
            n_bad++;
            $display("FAIL rand_scan[%0d]: bcd=%h sel=%b, want %h %b",
                     i, bus.bcd_o, bus.digit_sel_o_, exp_bcd(), exp_sel());
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      model_reset();
      test_reset();
      test_carry_wrap();
      test_priority();
      test_live_update();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/decimal_scan_controller.md
# decimal_scan_controller

Multi-digit BCD up/down counter with a time-multiplexed scan sequencer that shares one BCD-to-decimal decoder among DIGITS display positions. Each scan slot presents one digit's BCD code on `bcd_o` (fed directly to the decoder input) and enables that position via an active-low select. Inter-slot blanking drives the decoder's all-off code to suppress ghosting. Sits between the lab's control logic (count/load/clear strobes) and the decoder plus display driver.

## Interface
- `DIGITS`, default 4: number of BCD digits and display positions; legal range 1–8.
- `SCAN_DIV`, default 1000: clock cycles each digit is shown; must be ≥ 1.
- `BLANK_CYCLES`, default 2: cycles of blanking between slots; 0 disables blanking.
- `clk_i`, input, 1: single clock; all state updates on the rising edge.
- `reset_i_`, input, 1: asynchronous, active-low reset.
- `clear_i`, input, 1: synchronous clear of the count to 0.
- `load_i`, input, 1: synchronous load from `load_value_i`.
- `load_value_i`, input, 4*DIGITS: packed BCD value; nibble 0 is the least significant digit.
- `count_en_i`, input, 1: advance the count by one this cycle.
- `up_i`, input, 1: count direction; 1 counts up, 0 counts down.
- `count_o`, output, 4*DIGITS: registered packed BCD count.
- `carry_o`, output, 1: one-cycle pulse when the count wraps in either direction.
- `bcd_o`, output, 4: registered code for the decoder; 4'b1111 while blanking.
- `digit_sel_o_`, output, DIGITS: active-low position enable; at most one bit is low at any time.

## Operation
- Counter command priority per cycle: `clear_i` > `load_i` > `count_en_i`. Only the highest-priority asserted command takes effect.
- Load: any nibble of `load_value_i` greater than 9 is stored as 9. The other nibbles load unchanged.
- Count up: each digit 9→0 generates a carry into the next digit. All digits at 9 wraps the count to all 0 and pulses `carry_o`.
- Count down: each digit 0→9 generates a borrow. All digits at 0 wraps the count to all 9 and pulses `carry_o`.
- `carry_o` is never asserted on a clear or load cycle.
- Scan FSM states are SHOW and BLANK. It has a slot counter `cnt` and a digit index `k`.
- SHOW:
  - `bcd_o` is registered from count digit k every cycle, so a live count change is visible mid-slot.
  - `digit_sel_o_[k]` is 0; all other select bits are 1.
  - After SCAN_DIV cycles: go to BLANK, or straight to SHOW of the next digit if BLANK_CYCLES = 0.
- BLANK:
  - `bcd_o` = 4'b1111 and `digit_sel_o_` is all ones.
  - Lasts BLANK_CYCLES cycles, then goes to SHOW.
- Digit index k increments on each SHOW exit and wraps DIGITS−1 → 0.
- Counter commands never disturb the scan sequence, and the scan never affects counting.

## Timing
- Reset (asynchronous, mid-operation included) sets:
  - `count_o` = 0 and `carry_o` = 0
  - `bcd_o` = 4'b1111 and `digit_sel_o_` = all ones
  - FSM = BLANK, k = 0, `cnt` = 0
- First SHOW after reset release:
  - Digit 0 is shown after BLANK_CYCLES edges, or after 1 edge if BLANK_CYCLES = 0.
  - Selects stay all ones until that point.
- A command sampled at edge n appears on `count_o` after edge n. `carry_o` is high for exactly the cycle following edge n.
- `bcd_o` reflects a count change one cycle after `count_o` (2-cycle latency from the command) when that digit is being shown.
- Scan period is DIGITS × (SCAN_DIV + BLANK_CYCLES) cycles.
- `bcd_o` and `digit_sel_o_` change on the same edge, so decoder code and select are never misaligned.
- Case DIGITS = 1 with BLANK_CYCLES = 0: `digit_sel_o_` stays 0 permanently after the first SHOW.

## Structure
- Package `decimal_pkg` holds:
  - BCD digit constants ZERO..NINE
  - BLANK_CODE = 4'b1111
  - the scan state enum {SHOW, BLANK}
- Sub-module `bcd_digit_counter` implements one digit:
  - Inputs: clear, load (with saturation to 9), enable, up, carry-in.
  - Output: carry-out.
  - The top instantiates it DIGITS times in a ripple chain.
- The top contains the scan FSM and the output registers.

## Test plan
- Reset, then hold with SCAN_DIV=3, BLANK_CYCLES=2, DIGITS=4 → `bcd_o`=F and selects 1111 for 2 cycles, then digit 0 shown 3 cycles with select 1110. Sequence repeats with period 20.
- Load 16'h0999, count up once → `count_o`=16'h1000 one cycle later, `carry_o` stays 0.
- Load 16'h9999, count up → `count_o`=16'h0000 with a single-cycle `carry_o`. From 0000, count down → 9999 with a single-cycle `carry_o`.
- Load 16'h3AF5 → stored value 16'h3995. Clear, load and count asserted together → `count_o`=0 and `carry_o`=0.
- During SHOW of digit 1 with value 4, count up 1→ `bcd_o` becomes 5 two cycles after the command, and the select is unchanged.
- Assert `reset_i_` low mid-SHOW of digit 2 with no clock edge → all outputs take their reset values immediately. Scan restarts at digit 0.
